// File: rtl/resize_frame_uart_sender_if.sv
// resize_frame_uart_sender_if: pixel-in and uart_tx handshake bundle for the frame sender
interface resize_frame_uart_sender_if;
  logic       pix_vld;
  logic [7:0] pix_data;
  logic       pix_rdy;
  logic       tx_done;
  logic       trmt;
  logic [7:0] tx_data;
  logic       busy;
  logic       frame_sent;
  logic       ovf;
  modport master (
    output pix_vld, pix_data, tx_done,
    input  pix_rdy, trmt, tx_data, busy, frame_sent, ovf
  );
  modport slave (
    input  pix_vld, pix_data, tx_done,
    output pix_rdy, trmt, tx_data, busy, frame_sent, ovf
  );
endinterface

// File: rtl/resize_frame_uart_sender.sv
// resize_frame_uart_sender: buffers one averaged frame, then sends HDR0,HDR1,payload via uart_tx
// FRAME_CHECKSUM_EN appends a mod-256 payload checksum byte after the payload.
module resize_frame_uart_sender #(
  parameter int         IMG_W = 32,
  parameter int         IMG_H = 32,
  parameter logic [7:0] HDR0  = 8'hA5,
  parameter logic [7:0] HDR1  = 8'h5A
) (
  input logic clk,
  input logic rst_n,
  resize_frame_uart_sender_if.slave bus
);
  localparam int NPIX = IMG_W * IMG_H;
  localparam int AW = $clog2(NPIX);
  localparam logic [AW-1:0] LAST = AW'(NPIX - 1);
`ifdef FRAME_CHECKSUM_EN
  typedef enum logic [2:0] {S_IDLE, S_FILL, S_HDR0, S_HDR1, S_PAY, S_CSUM, S_DONE} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_FILL, S_HDR0, S_HDR1, S_PAY, S_DONE} state_t;
`endif
  typedef enum logic [1:0] {B_LOAD, B_GUARD, B_WAIT} sub_t;
  state_t        state_q, state_d;
  sub_t          sub_q, sub_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [7:0]    tx_data_q, tx_data_d, rd_data_q, cur_byte;
  logic          trmt_q, trmt_d, ovf_q, ovf_d;
  logic          filling, sending, byte_done, last_pay, wr_en;
  logic [7:0]    mem [NPIX];
`ifdef FRAME_CHECKSUM_EN
  logic [7:0]    csum_q, csum_d;
`endif
  always_comb begin
    filling   = state_q == S_IDLE || state_q == S_FILL;
    sending   = !filling && state_q != S_DONE;
    byte_done = sending && sub_q == B_WAIT && bus.tx_done;
    last_pay  = rd_ptr_q == LAST;
    wr_en     = filling && bus.pix_vld;
`ifdef FRAME_CHECKSUM_EN
    cur_byte = state_q == S_HDR0 ? HDR0 : state_q == S_HDR1 ? HDR1 : state_q == S_CSUM ? csum_q : rd_data_q;
    csum_d   = state_q == S_DONE ? 8'h00 : wr_en ? csum_q + bus.pix_data : csum_q;
`else
    cur_byte = state_q == S_HDR0 ? HDR0 : state_q == S_HDR1 ? HDR1 : rd_data_q;
`endif
    state_d   = state_q;
    sub_d     = sub_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    tx_data_d = tx_data_q;
    trmt_d    = 1'b0;
    ovf_d     = ovf_q || (bus.pix_vld && !filling);
    if (wr_en) begin
      wr_ptr_d = wr_ptr_q == LAST ? '0 : wr_ptr_q + 1'b1;
      state_d  = wr_ptr_q == LAST ? S_HDR0 : S_FILL;
    end
    // GUARD always follows LOAD so a tx_done still high from the previous byte is never taken
    if (sending) begin
      sub_d     = sub_q == B_LOAD ? B_GUARD : sub_q == B_GUARD ? B_WAIT : byte_done ? B_LOAD : B_WAIT;
      trmt_d    = sub_q == B_LOAD;
      tx_data_d = sub_q == B_LOAD ? cur_byte : tx_data_q;
    end
    if (byte_done && state_q == S_PAY)
      rd_ptr_d = last_pay ? '0 : rd_ptr_q + 1'b1;
    if (byte_done)
`ifdef FRAME_CHECKSUM_EN
      state_d = state_q == S_HDR0 ? S_HDR1 : state_q == S_HDR1 ? S_PAY :
                state_q == S_PAY ? (last_pay ? S_CSUM : S_PAY) : S_DONE;
`else
      state_d = state_q == S_HDR0 ? S_HDR1 : state_q == S_HDR1 ? S_PAY : last_pay ? S_DONE : S_PAY;
`endif
    if (state_q == S_DONE) begin
      state_d  = S_IDLE;
      rd_ptr_d = '0;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      sub_q     <= B_LOAD;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      tx_data_q <= 8'h00;
      trmt_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sub_q     <= sub_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      tx_data_q <= tx_data_d;
      trmt_q    <= trmt_d;
      ovf_q     <= ovf_d;
    end
  end
`ifdef FRAME_CHECKSUM_EN
  always_ff @(posedge clk)
    csum_q <= !rst_n ? 8'h00 : csum_d;
`endif
  // read addressed by the next pointer so mem[rd_ptr_q] is already registered at LOAD
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= bus.pix_data;
    rd_data_q <= mem[rd_ptr_d];
  end
  assign bus.pix_rdy    = filling;
  assign bus.trmt       = trmt_q;
  assign bus.tx_data    = tx_data_q;
  assign bus.busy       = state_q != S_IDLE && state_q != S_DONE;
  assign bus.frame_sent = state_q == S_DONE;
  assign bus.ovf        = ovf_q;
endmodule

// File: tb/tb_resize_frame_uart_sender.sv
// tb_resize_frame_uart_sender: directed checks of framing, latency, overflow, reset abort and stuck tx_done
module tb_resize_frame_uart_sender;
  localparam int NPIX = 1024;
  localparam int UART_LAT = 3;
`ifdef FRAME_CHECKSUM_EN
  localparam int NB = 1027;
  localparam logic [7:0] T3_LAST = 8'h2A;
`else
  localparam int NB = 1026;
  localparam logic [7:0] T3_LAST = 8'h00;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int cyc = 0;
  int npass = 0, ntot = 0;
  int ucnt = 0, fsn = 0, dbl = 0, unstable = 0, bad_int = 0, last_cyc = -1;
  bit stuck = 1'b0, prev_trmt = 1'b0;
  logic [7:0] held = 8'h00;
  logic [7:0] cap[$];
  logic [7:0] expq[$];
  resize_frame_uart_sender_if bus();
  resize_frame_uart_sender dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // uart_tx stand-in plus stream monitor, evaluated on the falling edge
  always @(negedge clk) begin
    if (!rst_n) ucnt = 0;
    else if (bus.trmt && !stuck) ucnt = UART_LAT;
    else if (ucnt > 0) ucnt--;
    bus.tx_done = ucnt == 0;
    if (bus.trmt) begin
      cap.push_back(bus.tx_data);
      if (prev_trmt) dbl++;
      if (stuck && last_cyc >= 0 && cyc - last_cyc != 3) bad_int++;
      last_cyc = cyc;
      held = bus.tx_data;
    end else if (rst_n && ucnt > 0 && bus.tx_data !== held) unstable++;
    prev_trmt = bus.trmt;
    if (bus.frame_sent) fsn++;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask
  function automatic logic [7:0] pix(input int pat, input int i);
    return pat == 0 ? 8'(i) : pat == 1 ? (i == 0 ? 8'h2A : 8'h00) : 8'(i * 7 + 3);
  endfunction
  task automatic build_exp(input int pat);
`ifdef FRAME_CHECKSUM_EN
    logic [7:0] s = 8'h00;
`endif
    expq.delete();
    expq.push_back(8'hA5);
    expq.push_back(8'h5A);
    for (int i = 0; i < NPIX; i++) begin
      expq.push_back(pix(pat, i));
`ifdef FRAME_CHECKSUM_EN
      s += pix(pat, i);
`endif
    end
`ifdef FRAME_CHECKSUM_EN
    expq.push_back(s);
`endif
  endtask
  task automatic send_frame(input int pat);
    chk("rdy_before_frame", bus.pix_rdy, 1);
    cap.delete();
    for (int i = 0; i < NPIX; i++) begin
      @(negedge clk);
      bus.pix_vld = 1'b1;
      bus.pix_data = pix(pat, i);
    end
    @(negedge clk);
    bus.pix_vld = 1'b0;
  endtask
  task automatic wait_frame(input int fs0);
    int t = 0;
    while (fsn == fs0 && t < 20000) begin
      @(negedge clk);
      t++;
    end
    chk("frame_timeout", t < 20000, 1);
    repeat (5) @(negedge clk);
    chk("frame_sent_pulses", fsn - fs0, 1);
  endtask
  task automatic cmp_stream(input string tag);
    int nbad = 0;
    chk({tag, "_len"}, cap.size(), expq.size());
    for (int i = 0; i < cap.size() && i < expq.size(); i++)
      if (cap[i] !== expq[i]) nbad++;
    chk({tag, "_bad_bytes"}, nbad, 0);
  endtask
  initial begin
    int fs0, n0, t;
    bus.pix_vld = 1'b0;
    bus.pix_data = 8'h00;
    // 1: reset state
    repeat (2) @(negedge clk);
    chk("rst_pix_rdy", bus.pix_rdy, 1);
    chk("rst_trmt", bus.trmt, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_ovf", bus.ovf, 0);
    chk("rst_tx_data", bus.tx_data, 8'h00);
    rst_n = 1'b1;
    @(negedge clk);
    // 2: ramp frame, latency and full stream
    fs0 = fsn;
    build_exp(0);
    send_frame(0);
    chk("t2_rdy_drop", bus.pix_rdy, 0);
    chk("t2_no_trmt_yet", bus.trmt, 0);
    chk("t2_busy", bus.busy, 1);
    @(negedge clk);
    chk("t2_first_trmt", bus.trmt, 1);
    chk("t2_first_byte", bus.tx_data, 8'hA5);
    wait_frame(fs0);
    chk("t2_count", cap.size(), NB);
    cmp_stream("t2_stream");
    chk("t2_busy_after", bus.busy, 0);
    chk("t2_ovf", bus.ovf, 0);
    // 3+4: checksum frame with overflow injection during payload
    fs0 = fsn;
    build_exp(1);
    send_frame(1);
    t = 0;
    while (cap.size() < 20 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk("t4_reach_pay", t < 2000, 1);
    bus.pix_vld = 1'b1;
    bus.pix_data = 8'h77;
    chk("t4_pix_rdy", bus.pix_rdy, 0);
    @(negedge clk);
    chk("t4_ovf", bus.ovf, 1);
    repeat (2) @(negedge clk);
    bus.pix_vld = 1'b0;
    wait_frame(fs0);
    chk("t3_count", cap.size(), NB);
    chk("t3_last_byte", cap[cap.size() - 1], T3_LAST);
    cmp_stream("t3_stream");
    chk("t4_ovf_sticky", bus.ovf, 1);
    // 5: reset after the 100th payload byte, then a fresh frame
    build_exp(0);
    send_frame(0);
    t = 0;
    while (cap.size() < 102 && t < 5000) begin
      @(negedge clk);
      t++;
    end
    chk("t5_reach", cap.size(), 102);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    n0 = cap.size();
    repeat (20) @(negedge clk);
    chk("t5_no_trmt", cap.size(), n0);
    chk("t5_busy", bus.busy, 0);
    chk("t5_pix_rdy", bus.pix_rdy, 1);
    chk("t5_ovf_cleared", bus.ovf, 0);
    fs0 = fsn;
    build_exp(2);
    send_frame(2);
    wait_frame(fs0);
    chk("t5_first_byte", cap[0], 8'hA5);
    cmp_stream("t5_stream");
    // 6: tx_done stuck high
    stuck = 1'b1;
    @(negedge clk);
    last_cyc = -1;
    fs0 = fsn;
    build_exp(0);
    send_frame(0);
    wait_frame(fs0);
    chk("t6_count", cap.size(), NB);
    chk("t6_bad_interval", bad_int, 0);
    cmp_stream("t6_stream");
    chk("double_trmt", dbl, 0);
    chk("tx_data_unstable", unstable, 0);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
